// File: rtl/kulisch_to_float.sv
// Converts a finished two's-complement Kulisch accumulator word into a packed
// {sign, biased exponent, mantissa} float: absolute value, 1-bit/cycle normalize, RNE.
module kulisch_to_float #(
    parameter int ACC_NON_FRAC = 8,
    parameter int ACC_FRAC     = 8,
    parameter int EXP          = 8,
    parameter int FRAC         = 7
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               inValid,
    output logic                               inReady,
    input  logic [ACC_NON_FRAC+ACC_FRAC-1:0]   accIn,
    input  logic                               accInInf,
    output logic                               outValid,
    input  logic                               outReady,
    output logic [EXP+FRAC:0]                  floatOut
);

    localparam int W    = ACC_NON_FRAC + ACC_FRAC;
    localparam int EW   = $clog2(W) + EXP + 2;
    localparam int GPOS = W - 2 - FRAC;

    localparam logic signed [EW-1:0] E_INIT   = EW'(W - 1 - ACC_FRAC);
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP - 1)) - 1);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP) - 1);
    localparam logic signed [EW-1:0] E_ONE    = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO   = EW'(0);
    localparam logic [W-1:0]         STICKY_M = (W'(1) << GPOS) - W'(1);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t                 r_state;
    logic                   r_sign;
    logic                   r_inf;
    logic [W-1:0]           r_mag;
    logic signed [EW-1:0]   r_exp;
    logic [EXP+FRAC:0]      r_float;

    state_t                 w_state_nxt;
    logic                   w_sign_nxt;
    logic                   w_inf_nxt;
    logic [W-1:0]           w_mag_nxt;
    logic signed [EW-1:0]   w_exp_nxt;
    logic [EXP+FRAC:0]      w_float_nxt;

    logic [W-1:0]           w_abs;
    logic [FRAC-1:0]        w_mant;
    logic                   w_guard;
    logic                   w_sticky;
    logic                   w_round_up;
    logic [FRAC:0]          w_mant_inc;
    logic [FRAC-1:0]        w_mant_rnd;
    logic signed [EW-1:0]   w_exp_rnd;
    logic signed [EW-1:0]   w_biased;
    logic [EXP+FRAC:0]      w_inf_word;
    logic [EXP+FRAC:0]      w_round_word;

    // The most negative input wraps back to itself, which read unsigned is 2^(W-1).
    assign w_abs = accIn[W-1] ? (~accIn + W'(1)) : accIn;

    assign w_mant     = r_mag[W-2 -: FRAC];
    assign w_guard    = r_mag[GPOS];
    assign w_sticky   = |(r_mag & STICKY_M);
    assign w_round_up = w_guard & (w_sticky | w_mant[0]);
    assign w_mant_inc = {1'b0, w_mant} + (FRAC+1)'(w_round_up);
    assign w_mant_rnd = w_mant_inc[FRAC-1:0];
    assign w_exp_rnd  = w_mant_inc[FRAC] ? (r_exp + E_ONE) : r_exp;
    assign w_biased   = w_exp_rnd + BIAS;

    assign w_inf_word = {r_sign, {EXP{1'b1}}, {FRAC{1'b0}}};

    always_comb begin
        if (w_biased >= EXP_MAX) begin
            w_round_word = w_inf_word;
        end else if (w_biased <= E_ZERO) begin
            w_round_word = {r_sign, {(EXP+FRAC){1'b0}}};
        end else begin
            w_round_word = {r_sign, w_biased[EXP-1:0], w_mant_rnd};
        end
    end

    // NOTE: every output of this block gets a default before the case so that
    // no path leaves one unassigned and infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_inf_nxt   = r_inf;
        w_mag_nxt   = r_mag;
        w_exp_nxt   = r_exp;
        w_float_nxt = r_float;
        unique case (r_state)
            IDLE: begin
                if (inValid && inReady) begin
                    w_sign_nxt  = accIn[W-1];
                    w_mag_nxt   = w_abs;
                    w_exp_nxt   = E_INIT;
                    w_inf_nxt   = accInInf;
                    w_state_nxt = NORM;
                end
            end
            NORM: begin
                if (r_inf) begin
                    w_float_nxt = w_inf_word;
                    w_state_nxt = DONE;
                end else if (r_mag == '0) begin
                    w_float_nxt = '0;
                    w_state_nxt = DONE;
                end else if (r_mag[W-1]) begin
                    w_state_nxt = ROUND;
                end else begin
                    w_mag_nxt = r_mag << 1;
                    w_exp_nxt = r_exp - E_ONE;
                end
            end
            ROUND: begin
                w_float_nxt = w_round_word;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (outReady) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sign  <= 1'b0;
            r_inf   <= 1'b0;
            r_mag   <= '0;
            r_exp   <= '0;
            r_float <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sign  <= w_sign_nxt;
            r_inf   <= w_inf_nxt;
            r_mag   <= w_mag_nxt;
            r_exp   <= w_exp_nxt;
            r_float <= w_float_nxt;
        end
    end

    assign inReady  = (r_state == IDLE) & reset;
    assign outValid = (r_state == DONE);
    assign floatOut = r_float;

endmodule

// File: tb/tb_kulisch_to_float.sv
// Bench for kulisch_to_float: arithmetic reference model plus a negedge monitor
// that checks result, latency and handshake behaviour of every conversion.
module tb_kulisch_to_float;

    localparam int W        = 16;
    localparam int ACC_FRAC = 8;

    logic        clock;
    logic        reset;
    logic        inValid;
    logic        inReady;
    logic [15:0] accIn;
    logic        accInInf;
    logic        outValid;
    logic        outReady;
    logic [15:0] floatOut;

    logic        sm_valid;
    logic        sm_ready;
    logic [15:0] sm_acc;
    logic        sm_inf;
    logic        sm_out_valid;
    logic        sm_out_ready;
    logic [7:0]  sm_float;

    kulisch_to_float dut (
        .clock    (clock),
        .reset    (reset),
        .inValid  (inValid),
        .inReady  (inReady),
        .accIn    (accIn),
        .accInInf (accInInf),
        .outValid (outValid),
        .outReady (outReady),
        .floatOut (floatOut)
    );

    kulisch_to_float #(.ACC_NON_FRAC(8), .ACC_FRAC(8), .EXP(3), .FRAC(4)) dut_small (
        .clock    (clock),
        .reset    (reset),
        .inValid  (sm_valid),
        .inReady  (sm_ready),
        .accIn    (sm_acc),
        .accInInf (sm_inf),
        .outValid (sm_out_valid),
        .outReady (sm_out_ready),
        .floatOut (sm_float)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int msb_pos(input longint m);
        int p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return p;
    endfunction

    // Value-level reference: round |x| to fw fraction bits (RNE), then range-limit.
    function automatic logic [31:0] model(input logic [15:0] a, input logic inf,
                                          input int ew, input int fw);
        longint v, mag, q, rem, half, res, inf_word;
        int p, sh, e, biased;
        v        = longint'($signed(a));
        mag      = (v < 0) ? -v : v;
        res      = ((v < 0) ? longint'(1) : longint'(0)) << (ew + fw);
        inf_word = res | (((longint'(1) << ew) - 1) << fw);
        if (inf) return 32'(inf_word);
        if (mag == 0) return 32'(0);
        p = msb_pos(mag);
        e = p - ACC_FRAC;
        if (p > fw) begin
            sh   = p - fw;
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q++;
        end else begin
            q = mag << (fw - p);
        end
        if (q == (longint'(2) << fw)) begin
            q = q >> 1;
            e++;
        end
        biased = e + (1 << (ew - 1)) - 1;
        if (biased >= (1 << ew) - 1) return 32'(inf_word);
        if (biased <= 0) return 32'(res);
        return 32'(res | (longint'(biased) << fw) | (q - (longint'(1) << fw)));
    endfunction

    function automatic int lat_of(input logic [15:0] a, input logic inf);
        longint v, mag;
        v   = longint'($signed(a));
        mag = (v < 0) ? -v : v;
        if (inf || mag == 0) return 1;
        return (W - 1 - msb_pos(mag)) + 2;
    endfunction

    typedef struct {
        logic [31:0] val;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   edge_cnt    = 0;
    int   accept_edge = 0;
    int   hs_edge     = 0;
    logic prev_ov     = 1'b0;
    logic hs_pending  = 1'b0;
    logic b2b         = 1'b0;

    always @(posedge clock) edge_cnt++;

    always @(negedge clock) begin
        if (!reset) begin
            prev_ov    = 1'b0;
            hs_pending = 1'b0;
        end else begin
            if (hs_pending) begin
                check("inReady after handshake", 32'(inReady), 32'd1);
                check("outValid after handshake", 32'(outValid), 32'd0);
                hs_pending = 1'b0;
            end
            if (outValid) begin
                if (exp_q.size() == 0) begin
                    check("outValid with nothing in flight", 32'(outValid), 32'd0);
                end else begin
                    if (!prev_ov)
                        check("latency", 32'(edge_cnt - accept_edge), 32'(exp_q[0].lat));
                    check("floatOut", 32'(floatOut), exp_q[0].val);
                    check("inReady in DONE", 32'(inReady), 32'd0);
                    if (outReady) begin
                        void'(exp_q.pop_front());
                        hs_pending = 1'b1;
                        hs_edge    = edge_cnt + 1;
                    end
                end
            end
            if (inValid && inReady) begin
                accept_edge = edge_cnt + 1;
                if (b2b)
                    check("accept one edge after handshake", 32'(accept_edge - hs_edge), 32'd1);
                exp_q.push_back('{val: model(accIn, accInInf, 8, 7), lat: lat_of(accIn, accInInf)});
            end
            prev_ov = outValid;
        end
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Present a word from the current (post-edge) point until it is accepted.
    task automatic send(input logic [15:0] a, input logic inf);
        int n = 0;
        accIn    = a;
        accInInf = inf;
        inValid  = 1'b1;
        @(negedge clock);
        while (!inReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!inReady) check("inReady within bound", 32'(inReady), 32'd1);
        @(posedge clock);
        #1;
        inValid  = 1'b0;
        accInInf = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("conversion completed", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [15:0] a, input logic inf, input logic [15:0] lit);
        check("model pin", model(a, inf, 8, 7), 32'(lit));
        sync();
        send(a, inf);
        wait_drain();
    endtask

    task automatic small_run(input logic [15:0] a, input logic inf, input logic [7:0] lit);
        logic [31:0] m;
        int n;
        m = model(a, inf, 3, 4);
        check("small model pin", m, 32'(lit));
        sync();
        sm_acc   = a;
        sm_inf   = inf;
        sm_valid = 1'b1;
        n = 0;
        @(negedge clock);
        while (!sm_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        sm_valid = 1'b0;
        sm_inf   = 1'b0;
        n = 0;
        @(negedge clock);
        while (!sm_out_valid && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("small outValid", 32'(sm_out_valid), 32'd1);
        check("small floatOut", 32'(sm_float), m);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        reset        = 1'b0;
        inValid      = 1'b0;
        accIn        = '0;
        accInInf     = 1'b0;
        outReady     = 1'b1;
        sm_valid     = 1'b0;
        sm_acc       = '0;
        sm_inf       = 1'b0;
        sm_out_ready = 1'b1;
        #1;
        check("reset inReady", 32'(inReady), 32'd0);
        check("reset outValid", 32'(outValid), 32'd0);
        check("reset floatOut", 32'(floatOut), 32'd0);
        #11;
        reset = 1'b1;
        @(negedge clock);
        check("inReady after release", 32'(inReady), 32'd1);

        run(16'h0100, 1'b0, 16'h3F80);
        run(16'hFF00, 1'b0, 16'hBF80);
        run(16'h0000, 1'b0, 16'h0000);
        run(16'hFF00, 1'b1, 16'hFF80);
        run(16'h0188, 1'b0, 16'h3FC4);
        run(16'h0181, 1'b0, 16'h3FC0);
        run(16'h0183, 1'b0, 16'h3FC2);
        run(16'h0101, 1'b0, 16'h3F80);
        run(16'h0103, 1'b0, 16'h3F82);
        run(16'h01FF, 1'b0, 16'h4000);
        run(16'h8000, 1'b0, 16'hC300);
        run(16'h0001, 1'b0, 16'h3B80);
        run(16'h7FFF, 1'b0, 16'h4300);
        run(16'hFFFF, 1'b0, 16'hBB80);

        // Backpressure, with the next word already waiting behind the result.
        sync();
        outReady = 1'b0;
        send(16'h0188, 1'b0);
        n = 0;
        while (!outValid && n < 100) begin
            @(negedge clock);
            n++;
        end
        repeat (5) @(negedge clock);
        sync();
        b2b      = 1'b1;
        outReady = 1'b1;
        send(16'h0100, 1'b0);
        b2b = 1'b0;
        wait_drain();

        // Reset in the middle of a long normalization.
        sync();
        send(16'h0001, 1'b0);
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("mid-conversion reset outValid", 32'(outValid), 32'd0);
        check("mid-conversion reset inReady", 32'(inReady), 32'd0);
        check("mid-conversion reset floatOut", 32'(floatOut), 32'd0);
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        check("inReady after mid reset", 32'(inReady), 32'd1);
        repeat (20) @(negedge clock);
        check("no output after abandoned conversion", 32'(outValid), 32'd0);
        run(16'h0100, 1'b0, 16'h3F80);

        small_run(16'h7F00, 1'b0, 8'h70);
        small_run(16'h1000, 1'b0, 8'h70);
        small_run(16'h0800, 1'b0, 8'h60);
        small_run(16'h0100, 1'b0, 8'h30);
        small_run(16'h0300, 1'b0, 8'h48);
        small_run(16'h0040, 1'b0, 8'h10);
        small_run(16'h0020, 1'b0, 8'h00);
        small_run(16'hFFE0, 1'b0, 8'h80);
        small_run(16'hFFFF, 1'b0, 8'h80);

        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
